// File: rtl/instruction_memory_loader_if.sv
// Stream-in / byte-write-out bundle for the instruction memory loader.
// The loader attaches to the slave modport, and the word source attaches to the master modport.
interface instruction_memory_loader_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  start;
  logic [31:0]           wordIn;
  logic                  wordValid;
  logic                  lastWord;
  logic                  wordReady;
  logic                  memWriteEnable;
  logic [ADDR_WIDTH-1:0] memWriteAddress;
  logic [7:0]            memWriteData;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [ADDR_WIDTH-2:0] wordsLoaded;

  modport master (
    output start, wordIn, wordValid, lastWord,
    input  wordReady, memWriteEnable, memWriteAddress, memWriteData,
    input  busy, done, overflow, wordsLoaded
  );

  modport slave (
    input  start, wordIn, wordValid, lastWord,
    output wordReady, memWriteEnable, memWriteAddress, memWriteData,
    output busy, done, overflow, wordsLoaded
  );
endinterface

// File: rtl/instruction_memory_loader.sv
// Loads 32-bit instruction words into a byte-wide memory as four big-endian byte writes.
// All outputs are decoded from registered state only.
module instruction_memory_loader #(
  parameter int MEM_BYTES  = 512,
  parameter int ADDR_WIDTH = 9,
  parameter int START_ADDR = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  instruction_memory_loader_if.slave    bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCEPT = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  // One extra address bit so that the address just past the end of memory stays distinguishable from 0.
  localparam logic [ADDR_WIDTH:0] START_A  = (ADDR_WIDTH+1)'(START_ADDR);
  localparam logic [ADDR_WIDTH:0] LAST_FIT = (ADDR_WIDTH+1)'(MEM_BYTES - 4);

  logic [2:0]            state_reg,    state_next;
  logic [ADDR_WIDTH:0]   addr_reg,     addr_next;
  logic [1:0]            byte_idx_reg, byte_idx_next;
  logic [31:0]           word_reg,     word_next;
  logic                  last_reg,     last_next;
  logic [ADDR_WIDTH-2:0] words_reg,    words_next;

  logic [7:0] word_bytes [4];
  logic       in_write;

  // word_bytes[0] holds the most significant byte, so byte index 0 lands at the lowest address.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
    assign word_bytes[gi] = word_reg[31-8*gi -: 8];
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    byte_idx_next = byte_idx_reg;
    word_next     = word_reg;
    last_next     = last_reg;
    words_next    = words_reg;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (bus.start) begin
          state_next = ST_ACCEPT;
          addr_next  = START_A;
          words_next = '0;
        end
      end
      ST_ACCEPT: begin
        if (bus.wordValid) begin
          if (addr_reg <= LAST_FIT) begin
            word_next     = bus.wordIn;
            last_next     = bus.lastWord;
            byte_idx_next = 2'd0;
            state_next    = ST_WRITE;
          end else begin
            state_next = ST_ERROR;
          end
        end
      end
      ST_WRITE: begin
        byte_idx_next = byte_idx_reg + 2'd1;
        if (byte_idx_reg == 2'd3) begin
          addr_next  = addr_reg + (ADDR_WIDTH+1)'(4);
          words_next = words_reg + (ADDR_WIDTH-1)'(1);
          state_next = last_reg ? ST_DONE : ST_ACCEPT;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      byte_idx_reg <= 2'd0;
      word_reg     <= '0;
      last_reg     <= 1'b0;
      words_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      byte_idx_reg <= byte_idx_next;
      word_reg     <= word_next;
      last_reg     <= last_next;
      words_reg    <= words_next;
    end
  end

  assign in_write            = (state_reg == ST_WRITE);
  assign bus.wordReady       = (state_reg == ST_ACCEPT);
  assign bus.memWriteEnable  = in_write;
  assign bus.memWriteAddress = in_write
                             ? addr_reg[ADDR_WIDTH-1:0] + {{(ADDR_WIDTH-2){1'b0}}, byte_idx_reg}
                             : '0;
  assign bus.memWriteData    = in_write ? word_bytes[byte_idx_reg] : 8'h00;
  assign bus.busy            = (state_reg == ST_ACCEPT) || in_write;
  assign bus.done            = (state_reg == ST_DONE);
  assign bus.overflow        = (state_reg == ST_ERROR);
  assign bus.wordsLoaded     = words_reg;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Scoreboard bench: two loaders (start 0 and start 504) run in lockstep from one stimulus,
// a word-level reference model queues the expected byte writes, and negedge monitors check them.
module tb_instruction_memory_loader;
  localparam int MEM  = 512;
  localparam int AW   = 9;
  localparam int MS_IDLE = 0, MS_LOAD = 1, MS_DONE = 2, MS_ERR = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        last_word = 1'b0;

  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;
  bit  mon_on = 0;

  int  q0[$];
  int  q1[$];
  int  m_addr[2];
  int  m_words[2];
  int  m_state[2];
  int  start_of[2];

  instruction_memory_loader_if #(.ADDR_WIDTH(AW)) bus0 ();
  instruction_memory_loader_if #(.ADDR_WIDTH(AW)) bus1 ();

  assign bus0.start = start;  assign bus0.wordIn = word_in;
  assign bus0.wordValid = word_valid;  assign bus0.lastWord = last_word;
  assign bus1.start = start;  assign bus1.wordIn = word_in;
  assign bus1.wordValid = word_valid;  assign bus1.lastWord = last_word;

  instruction_memory_loader #(.MEM_BYTES(MEM), .ADDR_WIDTH(AW), .START_ADDR(0)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0));
  instruction_memory_loader #(.MEM_BYTES(MEM), .ADDR_WIDTH(AW), .START_ADDR(504)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- reference model (word granularity) ----------------
  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_state[m] = MS_IDLE; m_words[m] = 0; m_addr[m] = 0;
    end
    q0.delete(); q1.delete();
  endfunction

  function automatic void model_start();
    for (int m = 0; m < 2; m++)
      if (m_state[m] != MS_LOAD) begin
        m_state[m] = MS_LOAD; m_addr[m] = start_of[m]; m_words[m] = 0;
      end
  endfunction

  function automatic void model_accept(logic [31:0] w, bit last);
    for (int m = 0; m < 2; m++) begin
      if (m_state[m] == MS_LOAD) begin
        if (m_addr[m] + 4 <= MEM) begin
          for (int i = 0; i < 4; i++) begin
            int v;
            v = ((m_addr[m] + i) << 8) | int'((w >> (24 - 8*i)) & 32'hFF);
            if (m == 0) q0.push_back(v); else q1.push_back(v);
          end
          m_addr[m] += 4;
          m_words[m]++;
          if (last) m_state[m] = MS_DONE;
        end else begin
          m_state[m] = MS_ERR;
        end
      end
    end
  endfunction

  // ---------------- monitors ----------------
  function automatic void mon(int m, logic en, logic [AW-1:0] a, logic [7:0] d);
    int e;
    bit have;
    have = 0; e = 0;
    if (en === 1'b1) begin
      if (m == 0) begin if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end end
      else        begin if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end end
      if (!have) begin
        tests++; fails++;
        $display("FAIL dut%0d unexpected write: got addr=%0d data=%02h, expected no write", m, a, d);
      end else begin
        check($sformatf("dut%0d write {addr,data}", m), {15'd0, a, d}, e);
      end
    end else begin
      check($sformatf("dut%0d enable", m), {31'd0, en}, 32'd0);
      check($sformatf("dut%0d idle addr/data", m), {15'd0, a, d}, 32'd0);
    end
  endfunction

  always @(negedge clock) begin
    if (mon_on) begin
      mon(0, bus0.memWriteEnable, bus0.memWriteAddress, bus0.memWriteData);
      mon(1, bus1.memWriteEnable, bus1.memWriteAddress, bus1.memWriteData);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic check_status(int m, logic dn, logic ov, logic bz, logic rd, logic [AW-2:0] wl);
    check($sformatf("dut%0d done", m),        {31'd0, dn}, {31'd0, m_state[m] == MS_DONE});
    check($sformatf("dut%0d overflow", m),    {31'd0, ov}, {31'd0, m_state[m] == MS_ERR});
    check($sformatf("dut%0d busy", m),        {31'd0, bz}, {31'd0, m_state[m] == MS_LOAD});
    check($sformatf("dut%0d wordReady", m),   {31'd0, rd}, {31'd0, m_state[m] == MS_LOAD});
    check($sformatf("dut%0d wordsLoaded", m), {24'd0, wl}, m_words[m]);
  endtask

  task automatic check_quiet();
    check_status(0, bus0.done, bus0.overflow, bus0.busy, bus0.wordReady, bus0.wordsLoaded);
    check_status(1, bus1.done, bus1.overflow, bus1.busy, bus1.wordReady, bus1.wordsLoaded);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, " dut0 outputs"}, {bus0.wordReady, bus0.memWriteEnable, bus0.memWriteAddress,
          bus0.memWriteData, bus0.busy, bus0.done, bus0.overflow, bus0.wordsLoaded}, 32'd0);
    check({tag, " dut1 outputs"}, {bus1.wordReady, bus1.memWriteEnable, bus1.memWriteAddress,
          bus1.memWriteData, bus1.busy, bus1.done, bus1.overflow, bus1.wordsLoaded}, 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    model_start();
    tick();
    start = 1'b0;
    check_quiet();
  endtask

  task automatic send_word(input logic [31:0] w, input bit last, output int acc_cyc);
    bit got;
    got = 0; acc_cyc = -1;
    word_in = w; last_word = last; word_valid = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      if (bus0.wordReady) begin
        got = 1; acc_cyc = cyc;
        model_accept(w, last);
        $display("[TB] cycle %0d word %08h last=%0b accepted", cyc, w, last);
      end
      tick();
    end
    word_valid = 1'b0; last_word = 1'b0;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL handshake: got no wordReady within 20 cycles, expected a handshake");
    end
  endtask

  task automatic wait_done(output int done_cyc);
    done_cyc = -1;
    for (int n = 0; n < 1000 && done_cyc < 0; n++) begin
      if (bus0.done || bus0.overflow) done_cyc = cyc;
      else tick();
    end
    tests++;
    if (done_cyc < 0) begin
      fails++;
      $display("FAIL wait_done: got no done/overflow within 1000 cycles, expected completion");
    end
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc, acc0, dc, n;
    logic [31:0] w;
    start_of[0] = 0; start_of[1] = 504;

    reset = 1'b1; tick(); tick(); reset = 1'b0;
    model_reset();
    mon_on = 1;
    check_all_zero("after reset");

    // single word, big-endian byte order and latency
    do_start();
    send_word(32'h21080008, 1'b1, acc);
    wait_done(dc);
    check("t1 done latency", dc - acc, 5);
    check_quiet();

    // 12 words back-to-back; dut1 (start 504) overflows on its 3rd word
    do_start();
    for (int i = 0; i < 12; i++) begin
      send_word($urandom, i == 11, acc);
      if (i == 0) acc0 = acc;
    end
    wait_done(dc);
    check("t2 done latency", dc - acc0, 60);
    check_quiet();

    // gaps in wordValid while in ACCEPT
    do_start();
    for (int i = 0; i < 4; i++) begin
      send_word($urandom, i == 3, acc);
      if (i < 3) begin
        for (int k = 0; k < 10 && !bus0.wordReady; k++) tick();
        for (int k = 0; k < 3; k++) begin
          check("t3 gap wordReady", {31'd0, bus0.wordReady}, 32'd1);
          check("t3 gap no write", {31'd0, bus0.memWriteEnable}, 32'd0);
          tick();
        end
      end
    end
    wait_done(dc);
    check_quiet();

    // reset on the 2nd byte write of a word
    do_start();
    send_word(32'hA1B2C3D4, 1'b0, acc);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    model_reset();
    check_all_zero("t5 mid-word reset");
    do_start();
    send_word(32'h0BADF00D, 1'b1, acc);
    wait_done(dc);
    check_quiet();

    // start during WRITE ignored; start in DONE restarts and overwrites from START_ADDR
    do_start();
    send_word(32'h11223344, 1'b0, acc);
    start = 1'b1; model_start(); tick(); start = 1'b0;
    send_word(32'h55667788, 1'b1, acc);
    wait_done(dc);
    check_quiet();
    do_start();
    send_word(32'hCAFEBABE, 1'b1, acc);
    wait_done(dc);
    check_quiet();

    // fill dut0 completely: 128 words fit, the 129th overflows
    do_start();
    for (int i = 0; i < 129; i++) send_word($urandom, 1'b0, acc);
    wait_done(dc);
    check_quiet();

    // randomized loads with random gaps
    for (int r = 0; r < 3; r++) begin
      do_start();
      n = $urandom_range(3, 12);
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        send_word(w, i == n - 1, acc);
        for (int g = $urandom_range(0, 3); g > 0; g--) tick();
      end
      wait_done(dc);
      check_quiet();
    end

    tick(); tick();
    check("dut0 scoreboard drained", q0.size(), 0);
    check("dut1 scoreboard drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running at 1 ms, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
